pcie_rx_block_deserializer: RTL and testbench

Multi-lane serial-to-parallel deserializer with 128b/130b block alignment for the PCIe PHY RX path. It sits between the per-lane serial front end and the descrambler/lane-deskew stage. Each lane accumulates `SERIAL_WIDTH` bits per clock into 130-bit blocks and hunts for block alignment by checking sync headers. Once a lane is locked, it emits a 2-bit sync header plus a 128-bit payload per block with a one-cycle valid strobe.

---
 rtl/pcie_rx_pkg.sv | 16 +
 rtl/pcie_rx_lane_block_sync.sv | 133 +++++++++++++
 rtl/pcie_rx_block_deserializer.sv | 40 ++++
 tb/tb_pcie_rx_block_deserializer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rx_pkg.sv
// Shared types and sync-header helpers for the PCIe RX 128b/130b block aligner.
package pcie_rx_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } blk_sync_state_e;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [1:0] SYNC_HDR_OS   = 2'b01;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_OS);
  endfunction

endpackage

// File: rtl/pcie_rx_lane_block_sync.sv
// One lane: serial-to-block gearbox with bit-slip, plus the HUNT/LOCKED alignment FSM.
// Handshake: block_valid_o is a one-cycle strobe with no backpressure; hdr_err_o qualifies it.
module pcie_rx_lane_block_sync
  import pcie_rx_pkg::*;
#(
  parameter int SERIAL_WIDTH  = 1,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_COUNT  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SERIAL_WIDTH-1:0]  serial_i,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  output logic [1:0]               sync_hdr_o,
  output logic                     block_valid_o,
  output logic                     hdr_err_o,
  output logic                     block_lock_o
);

  localparam int BLK_W = PAYLOAD_WIDTH + 2;
  localparam int BUF_W = BLK_W + SERIAL_WIDTH;
  localparam int FW    = $clog2(BUF_W + 1) + 1;
  localparam int GW    = $clog2(LOCK_COUNT + 1);
  localparam int BW    = $clog2(UNLOCK_COUNT + 1);
  localparam logic signed [FW-1:0] BLK_F  = FW'(BLK_W);
  localparam logic signed [FW-1:0] SW_F   = FW'(SERIAL_WIDTH);
  localparam logic signed [FW-1:0] ONE_F  = FW'(1);
  localparam logic signed [FW-1:0] ZERO_F = FW'(0);

  // Valid bits always sit in the low fill positions, newest at bit 0. A slip on a
  // block that ends exactly at the buffer edge drives fill to -1, which simply
  // drops the next incoming bit.
  logic [BLK_W-1:0]         buf_q, buf_d;
  logic [BUF_W-1:0]         buf_cat;
  logic signed [FW-1:0]     fill_q, fill_d, fill_cat, shift_amt;
  logic [BLK_W-1:0]         blk;
  logic                     blk_done, hdr_ok, slip;
  blk_sync_state_e          state_q, state_d;
  logic [GW-1:0]            good_q, good_d;
  logic [BW-1:0]            bad_q, bad_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic [1:0]               hdr_q, hdr_d;
  logic                     valid_q, valid_d, err_q, err_d;

  assign buf_cat   = {buf_q, serial_i};
  assign fill_cat  = fill_q + SW_F;
  assign blk_done  = (fill_cat >= BLK_F);
  assign shift_amt = fill_cat - BLK_F;
  assign blk       = BLK_W'(buf_cat >> $unsigned(shift_amt));
  assign hdr_ok    = hdr_is_valid(blk[BLK_W-1 -: 2]);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    bad_d     = bad_q;
    slip      = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    payload_d = payload_q;
    hdr_d     = hdr_q;
    if (blk_done) begin
      case (state_q)
        HUNT: begin
          if (hdr_ok) begin
            if (good_q >= GW'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              good_d  = GW'(LOCK_COUNT);
              bad_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            slip   = 1'b1;
            good_d = '0;
          end
        end
        default: begin
          valid_d   = 1'b1;
          err_d     = ~hdr_ok;
          payload_d = blk[PAYLOAD_WIDTH-1:0];
          hdr_d     = blk[BLK_W-1 -: 2];
          if (!hdr_ok) begin
            if (bad_q >= BW'(UNLOCK_COUNT - 1)) begin
              state_d = HUNT;
              slip    = 1'b1;
              good_d  = '0;
              bad_d   = BW'(UNLOCK_COUNT);
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end else begin
            bad_d = '0;
          end
        end
      endcase
    end
  end

  assign buf_d  = buf_cat[BLK_W-1:0];
  assign fill_d = blk_done ? (fill_cat - BLK_F - (slip ? ONE_F : ZERO_F)) : fill_cat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q     <= '0;
      fill_q    <= '0;
      state_q   <= HUNT;
      good_q    <= '0;
      bad_q     <= '0;
      payload_q <= '0;
      hdr_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      payload_q <= payload_d;
      hdr_q     <= hdr_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign payload_o     = payload_q;
  assign sync_hdr_o    = hdr_q;
  assign block_valid_o = valid_q;
  assign hdr_err_o     = err_q;
  assign block_lock_o  = (state_q == LOCKED);

endmodule

// File: rtl/pcie_rx_block_deserializer.sv
// Multi-lane 128b/130b block deserializer: independent per-lane aligners plus a lock summary.
module pcie_rx_block_deserializer #(
  parameter int NUM_LANES     = 1,
  parameter int SERIAL_WIDTH  = 1,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_COUNT  = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_LANES*SERIAL_WIDTH-1:0]  serial_data_in,
  output logic [NUM_LANES*PAYLOAD_WIDTH-1:0] payload_out,
  output logic [NUM_LANES*2-1:0]             sync_hdr_out,
  output logic [NUM_LANES-1:0]               block_valid,
  output logic [NUM_LANES-1:0]               hdr_err,
  output logic [NUM_LANES-1:0]               block_lock,
  output logic                               all_locked
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pcie_rx_lane_block_sync #(
      .SERIAL_WIDTH  (SERIAL_WIDTH),
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
      .LOCK_COUNT    (LOCK_COUNT),
      .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) u_lane (
      .clk           (clk),
      .reset_n       (reset_n),
      .serial_i      (serial_data_in[l*SERIAL_WIDTH +: SERIAL_WIDTH]),
      .payload_o     (payload_out[l*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .sync_hdr_o    (sync_hdr_out[l*2 +: 2]),
      .block_valid_o (block_valid[l]),
      .hdr_err_o     (hdr_err[l]),
      .block_lock_o  (block_lock[l])
    );
  end

  assign all_locked = &block_lock;

endmodule

// File: tb/tb_pcie_rx_block_deserializer.sv
// Bench: a 4-lane SW=1 instance and a 1-lane SW=8 instance, checked against a bit-stream alignment model.
`timescale 1ns/1ps
module tb_pcie_rx_block_deserializer;

  localparam int PW = 128;
  localparam int NM = 5;
  localparam int LOCK_N = 4;
  localparam int UNLOCK_N = 8;
  localparam logic [PW-1:0] P0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [3:0]      ser_a;
  logic [4*PW-1:0] pl_a;
  logic [7:0]      hdr_a;
  logic [3:0]      bv_a, err_a, lock_a;
  logic            all_a;
  logic [7:0]      ser_b;
  logic [PW-1:0]   pl_b;
  logic [1:0]      hdr_b;
  logic            bv_b, err_b, lock_b, all_b;

  pcie_rx_block_deserializer #(.NUM_LANES(4), .SERIAL_WIDTH(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .serial_data_in(ser_a), .payload_out(pl_a),
    .sync_hdr_out(hdr_a), .block_valid(bv_a), .hdr_err(err_a), .block_lock(lock_a),
    .all_locked(all_a));

  pcie_rx_block_deserializer #(.NUM_LANES(1), .SERIAL_WIDTH(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .serial_data_in(ser_b), .payload_out(pl_b),
    .sync_hdr_out(hdr_b), .block_valid(bv_b), .hdr_err(err_b), .block_lock(lock_b),
    .all_locked(all_b));

  logic [PW-1:0] mon_pl[NM];
  logic [1:0]    mon_hdr[NM];
  logic          mon_bv[NM], mon_err[NM], mon_lock[NM];
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      mon_pl[l]   = pl_a[l*PW +: PW];
      mon_hdr[l]  = hdr_a[l*2 +: 2];
      mon_bv[l]   = bv_a[l];
      mon_err[l]  = err_a[l];
      mon_lock[l] = lock_a[l];
    end
    mon_pl[4]   = pl_b;
    mon_hdr[4]  = hdr_b;
    mon_bv[4]   = bv_b;
    mon_err[4]  = err_b;
    mon_lock[4] = lock_b;
  end

  // Model: full received bit history per lane; pos is the next candidate block start.
  bit              tx[NM][$];
  bit              hist[NM][$];
  int              pos[NM], good[NM], bad[NM];
  bit              mlock[NM], exp_strobe[NM];
  logic [PW+2:0]   exp_q[NM][$];
  int              vectors = 0, miscompares = 0;
  int              cyc = 0, last_b = -1;
  bit              mon_en = 1'b0;

  task automatic chk(input string name, input int lane, input logic [PW+2:0] act,
                     input logic [PW+2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane %0d: got %h expected %h", name, lane, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_block(input int l, input logic [1:0] h, input logic [PW-1:0] p);
    tx[l].push_back(h[1]);
    tx[l].push_back(h[0]);
    for (int i = PW - 1; i >= 0; i--) tx[l].push_back(p[i]);
  endtask

  task automatic push_ones(input int l, input int n);
    for (int i = 0; i < n; i++) tx[l].push_back(1'b1);
  endtask

  task automatic model_reset();
    for (int l = 0; l < NM; l++) begin
      tx[l].delete();
      hist[l].delete();
      exp_q[l].delete();
      pos[l] = 0; good[l] = 0; bad[l] = 0;
      mlock[l] = 1'b0; exp_strobe[l] = 1'b0;
    end
    last_b = -1;
  endtask

  task automatic model_eval(input int l);
    logic [1:0]    h;
    logic [PW-1:0] p;
    bit            ok, slip_now;
    exp_strobe[l] = 1'b0;
    if (hist[l].size() < pos[l] + PW + 2) return;
    h = {hist[l][pos[l]], hist[l][pos[l]+1]};
    for (int i = 0; i < PW; i++) p[PW-1-i] = hist[l][pos[l]+2+i];
    ok = (h == 2'b10) || (h == 2'b01);
    slip_now = 1'b0;
    if (!mlock[l]) begin
      if (ok) begin
        good[l]++;
        if (good[l] >= LOCK_N) begin mlock[l] = 1'b1; bad[l] = 0; end
      end else begin
        slip_now = 1'b1;
        good[l] = 0;
      end
    end else begin
      exp_strobe[l] = 1'b1;
      exp_q[l].push_back({!ok, h, p});
      if (!ok) begin
        bad[l]++;
        if (bad[l] >= UNLOCK_N) begin mlock[l] = 1'b0; good[l] = 0; slip_now = 1'b1; end
      end else begin
        bad[l] = 0;
      end
    end
    pos[l] += PW + 2 + (slip_now ? 1 : 0);
  endtask

  task automatic drive_cycle();
    logic [3:0] a;
    logic [7:0] b;
    bit         bt;
    a = '0;
    b = '0;
    for (int l = 0; l < NM; l++) begin
      for (int k = ((l == 4) ? 7 : 0); k >= 0; k--) begin
        if (tx[l].size() > 0) bt = tx[l].pop_front();
        else bt = 1'($urandom_range(0, 1));
        hist[l].push_back(bt);
        if (l == 4) b[k] = bt;
        else a[l] = bt;
      end
      model_eval(l);
    end
    ser_a = a;
    ser_b = b;
  endtask

  // Monitor: compares every cycle after the active edge; pops the scoreboard on each strobe.
  initial begin : monitor
    logic [PW+2:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        for (int l = 0; l < NM; l++) begin
          chk("block_valid", l, (PW+3)'(mon_bv[l]), (PW+3)'(exp_strobe[l]));
          chk("block_lock", l, (PW+3)'(mon_lock[l]), (PW+3)'(mlock[l]));
          if (exp_strobe[l] && exp_q[l].size() > 0) begin
            e = exp_q[l].pop_front();
            if (mon_bv[l]) chk("block_data", l, {mon_err[l], mon_hdr[l], mon_pl[l]}, e);
          end
          if (!mon_bv[l]) chk("hdr_err_idle", l, (PW+3)'(mon_err[l]), '0);
        end
        if (mon_bv[4]) begin
          if (last_b >= 0) begin
            vectors++;
            if (cyc - last_b < 16 || cyc - last_b > 17) begin
              miscompares++;
              $display("FAIL strobe_spacing lane 4: got %0d cycles expected 16 or 17", cyc - last_b);
            end
          end
          last_b = cyc;
        end
        chk("all_locked_a", 0, (PW+3)'(all_a),
            (PW+3)'(mlock[0] & mlock[1] & mlock[2] & mlock[3]));
        chk("all_locked_b", 4, (PW+3)'(all_b), (PW+3)'(mlock[4]));
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_cycle();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    drive_cycle();
  endtask

  initial begin : stimulus
    logic [PW-1:0] base;
    reset_n = 1'b0;
    ser_a = '0;
    ser_b = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Phase A: lane 0 aligned lock, header errors, unlock; lanes 1-3 offset 1/5/7; SW=8 gearbox.
    for (int i = 0; i < 6; i++) push_block(0, 2'b10, P0);
    for (int i = 0; i < 7; i++) push_block(0, 2'b00, rand128());
    push_block(0, 2'b01, rand128());
    for (int i = 0; i < 8; i++) push_block(0, (i % 2 == 0) ? 2'b00 : 2'b11, rand128());
    for (int i = 0; i < 8; i++) push_block(0, 2'b10, rand128());
    push_ones(1, 1);
    push_ones(2, 5);
    push_ones(3, 7);
    for (int l = 1; l < 4; l++) begin
      for (int i = 0; i < 12; i++) push_block(l, 2'b10, '1);
      for (int i = 0; i < 18; i++) push_block(l, 2'b10, rand128());
    end
    base = rand128();
    for (int i = 0; i < 260; i++) push_block(4, 2'b10, base + PW'(i));
    release_reset();
    run_cycles(4099);

    // Mid-block asynchronous reset: outputs must clear without a clock edge.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    for (int l = 0; l < NM; l++) begin
      chk("rst_data", l, {mon_err[l], mon_hdr[l], mon_pl[l]}, '0);
      chk("rst_valid", l, (PW+3)'(mon_bv[l]), '0);
      chk("rst_lock", l, (PW+3)'(mon_lock[l]), '0);
    end
    chk("rst_all_locked_a", 0, (PW+3)'(all_a), '0);
    chk("rst_all_locked_b", 4, (PW+3)'(all_b), '0);
    repeat (3) @(negedge clk);
    model_reset();

    // Phase B: relock from HUNT, three-bit offset lane, SW=8 with scattered header errors.
    for (int i = 0; i < 6; i++) push_block(0, 2'b10, P0);
    push_ones(1, 3);
    push_ones(2, 5);
    push_ones(3, 7);
    for (int l = 1; l < 4; l++)
      for (int i = 0; i < 13; i++) push_block(l, 2'b10, '1);
    for (int i = 0; i < 4; i++) push_block(4, 2'b10, rand128());
    for (int i = 0; i < 8; i++)
      push_block(4, (i % 3 == 1) ? 2'b00 : ((i % 3 == 0) ? 2'b01 : 2'b10), rand128());
    for (int i = 0; i < 100; i++) push_block(4, 2'b10, rand128());
    release_reset();
    run_cycles(1699);

    @(posedge clk);
    #2;
    for (int l = 0; l < NM; l++) chk("leftover_expected", l, (PW+3)'(exp_q[l].size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
